hazard_stall_ctrl: RTL and testbench

//  Decode-side hazard/stall controller; complements the EX-stage forwarding unit. Forwarding

---
 rtl/hazard_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Decode-side hazard/stall controller: load-use bubble, taken-branch flush, and
// memory-wait freeze with timeout, plus saturating stall/flush statistics.
module hazard_stall_ctrl #(
   parameter int REG_W   = 2,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4,
   parameter int STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_W-1:0]  readReg1_IFID,
   input  logic [REG_W-1:0]  readReg2_IFID,
   input  logic              usesRs2_IFID,
   input  logic              window_IFID,
   input  logic [REG_W-1:0]  destReg_IDEX,
   input  logic              memRead_IDEX,
   input  logic              window_IDEX,
   input  logic              branchTaken_EX,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pcWrite,
   output logic              ifidWrite,
   output logic              idexWrite,
   output logic              exmWrite,
   output logic              idexBubble,
   output logic              ifidFlush,
   output logic              mem_timeout,
   output logic [STAT_W-1:0] stall_cycles,
   output logic [STAT_W-1:0] flush_count
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_ERROR    = 2'd2;

   logic [1:0]        st_q, st_d;
   logic [CNT_W-1:0]  wcnt_q, wcnt_d;
   logic              timeout_q, timeout_d;
   logic [STAT_W-1:0] stall_q, stall_d;
   logic [STAT_W-1:0] flush_q, flush_d;
   logic              load_use;
   logic              freeze;

   always_comb begin
      load_use = memRead_IDEX && (destReg_IDEX != '0) && (window_IDEX == window_IFID) &&
                 ((destReg_IDEX == readReg1_IFID) ||
                  (usesRs2_IFID && (destReg_IDEX == readReg2_IFID)));
      freeze   = ((st_q == ST_RUN) && mem_req && !mem_ready) ||
                 ((st_q == ST_MEM_WAIT) && !mem_ready) ||
                 (st_q == ST_ERROR);
   end

   // Priority: reset > freeze > branch > load-use > normal
   always_comb begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      exmWrite   = 1'b1;
      idexBubble = 1'b0;
      ifidFlush  = 1'b0;
      if (rst || freeze) begin
         pcWrite   = 1'b0;
         ifidWrite = 1'b0;
         idexWrite = 1'b0;
         exmWrite  = 1'b0;
      end else if (branchTaken_EX) begin
         ifidFlush  = 1'b1;
         idexBubble = 1'b1;
      end else if (load_use) begin
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         idexBubble = 1'b1;
      end
   end

   always_comb begin
      st_d      = st_q;
      wcnt_d    = wcnt_q;
      timeout_d = timeout_q;
      case (st_q)
         ST_RUN: begin
            if (mem_req && !mem_ready) begin
               st_d   = ST_MEM_WAIT;
               wcnt_d = CNT_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               st_d   = ST_RUN;
               wcnt_d = '0;
            end else if (wcnt_q == CNT_W'(TIMEOUT)) begin
               st_d      = ST_ERROR;
               timeout_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         ST_ERROR: st_d = ST_ERROR;
         default:  st_d = ST_RUN;
      endcase
      stall_d = (!pcWrite && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
      flush_d = (ifidFlush && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q      <= ST_RUN;
         wcnt_q    <= '0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         st_q      <= st_d;
         wcnt_q    <= wcnt_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   assign mem_timeout  = timeout_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;

   localparam int REG_W   = 2;
   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 4;
   localparam int STAT_W  = 16;

   localparam logic [5:0] C_NORM   = 6'b111100;
   localparam logic [5:0] C_LOAD   = 6'b001110;
   localparam logic [5:0] C_BRANCH = 6'b111111;
   localparam logic [5:0] C_FREEZE = 6'b000000;

   logic              clk = 1'b0;
   logic              rst;
   logic [REG_W-1:0]  readReg1_IFID, readReg2_IFID, destReg_IDEX;
   logic              usesRs2_IFID, window_IFID, memRead_IDEX, window_IDEX;
   logic              branchTaken_EX, mem_req, mem_ready;
   logic              pcWrite, ifidWrite, idexWrite, exmWrite, idexBubble, ifidFlush;
   logic              mem_timeout;
   logic [STAT_W-1:0] stall_cycles, flush_count;
   logic [5:0]        ctrl;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clk = ~clk;

   assign ctrl = {pcWrite, ifidWrite, idexWrite, exmWrite, idexBubble, ifidFlush};

   hazard_stall_ctrl #(
      .REG_W(REG_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .readReg1_IFID(readReg1_IFID), .readReg2_IFID(readReg2_IFID),
      .usesRs2_IFID(usesRs2_IFID), .window_IFID(window_IFID),
      .destReg_IDEX(destReg_IDEX), .memRead_IDEX(memRead_IDEX),
      .window_IDEX(window_IDEX), .branchTaken_EX(branchTaken_EX),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
      .exmWrite(exmWrite), .idexBubble(idexBubble), .ifidFlush(ifidFlush),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      readReg1_IFID = '0; readReg2_IFID = '0; usesRs2_IFID = 1'b0; window_IFID = 1'b0;
      destReg_IDEX = '0; memRead_IDEX = 1'b0; window_IDEX = 1'b0;
      branchTaken_EX = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cyc();
   endtask

   task automatic set_load(input logic [REG_W-1:0] d, input logic [REG_W-1:0] r1,
                           input logic [REG_W-1:0] r2, input logic u2, input logic wx);
      memRead_IDEX = 1'b1; destReg_IDEX = d; readReg1_IFID = r1;
      readReg2_IFID = r2; usesRs2_IFID = u2; window_IDEX = wx; window_IFID = 1'b0;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      #3;
      chk("reset_ctrl", 32'(ctrl), 32'(C_FREEZE));
      chk("reset_stall", 32'(stall_cycles), 0);
      chk("reset_flush", 32'(flush_count), 0);
      chk("reset_timeout", 32'(mem_timeout), 0);
      @(negedge clk);
      rst = 1'b0;
      cyc();
      #1 chk("idle_normal", 32'(ctrl), 32'(C_NORM));

      // Load-use: one bubble, then the load has moved on
      set_load(2'd2, 2'd2, 2'd0, 1'b0, 1'b0);
      #1 chk("lu_ctrl", 32'(ctrl), 32'(C_LOAD));
      cyc();
      chk("lu_stall1", 32'(stall_cycles), 1);
      idle_inputs();
      #1 chk("lu_after", 32'(ctrl), 32'(C_NORM));

      // Non-hazards
      set_load(2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
      #1 chk("nh_r0", 32'(ctrl), 32'(C_NORM));
      set_load(2'd2, 2'd2, 2'd0, 1'b0, 1'b1);
      #1 chk("nh_window", 32'(ctrl), 32'(C_NORM));
      set_load(2'd2, 2'd1, 2'd2, 1'b0, 1'b0);
      #1 chk("nh_rs2_unused", 32'(ctrl), 32'(C_NORM));
      set_load(2'd2, 2'd1, 2'd2, 1'b1, 1'b0);
      #1 chk("lu_rs2", 32'(ctrl), 32'(C_LOAD));
      set_load(2'd3, 2'd3, 2'd0, 1'b0, 1'b0);
      memRead_IDEX = 1'b0;
      #1 chk("nh_noload", 32'(ctrl), 32'(C_NORM));
      cyc();
      chk("nh_stall", 32'(stall_cycles), 1);

      // Branch beats load-use
      idle_inputs();
      do_reset();
      chk("rst_clears_stall", 32'(stall_cycles), 0);
      set_load(2'd2, 2'd2, 2'd0, 1'b0, 1'b0);
      branchTaken_EX = 1'b1;
      #1 chk("br_lu_ctrl", 32'(ctrl), 32'(C_BRANCH));
      cyc();
      idle_inputs();
      chk("br_flush", 32'(flush_count), 1);
      chk("br_stall", 32'(stall_cycles), 0);

      // Multi-cycle memory access; branch held during freeze applies afterwards
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1 chk("mw_c1", 32'(ctrl), 32'(C_FREEZE));
      cyc();
      #1 chk("mw_c2", 32'(ctrl), 32'(C_FREEZE));
      cyc();
      branchTaken_EX = 1'b1;
      #1 chk("mw_c3_br", 32'(ctrl), 32'(C_FREEZE));
      cyc();
      chk("mw_noflush_frozen", 32'(flush_count), 0);
      mem_ready = 1'b1;
      #1 chk("mw_c4_br", 32'(ctrl), 32'(C_BRANCH));
      cyc();
      branchTaken_EX = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
      chk("mw_stall3", 32'(stall_cycles), 3);
      chk("mw_flush1", 32'(flush_count), 1);
      #1 chk("mw_run", 32'(ctrl), 32'(C_NORM));
      mem_req = 1'b1; mem_ready = 1'b1;
      #1 chk("single_access", 32'(ctrl), 32'(C_NORM));
      cyc();
      mem_req = 1'b0; mem_ready = 1'b0;
      #1 chk("single_run", 32'(ctrl), 32'(C_NORM));
      chk("single_stall", 32'(stall_cycles), 3);

      // Timeout
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int k = 1; k <= TIMEOUT + 2; k++) begin
         #1;
         chk($sformatf("to_ctrl_%0d", k), 32'(ctrl), 32'(C_FREEZE));
         chk($sformatf("to_flag_%0d", k), 32'(mem_timeout), (k >= TIMEOUT + 2) ? 1 : 0);
         cyc();
      end
      mem_req = 1'b0; mem_ready = 1'b1;
      #1 chk("err_frozen", 32'(ctrl), 32'(C_FREEZE));
      chk("err_stall", 32'(stall_cycles), TIMEOUT + 2);
      rst = 1'b1;
      #1;
      chk("async_rst_timeout", 32'(mem_timeout), 0);
      chk("async_rst_stall", 32'(stall_cycles), 0);
      chk("async_rst_ctrl", 32'(ctrl), 32'(C_FREEZE));
      @(negedge clk);
      rst = 1'b0;
      cyc();
      #1 chk("post_err_run", 32'(ctrl), 32'(C_NORM));

      // Saturation of stall_cycles
      mem_req = 1'b1; mem_ready = 1'b0;
      repeat (65540) cyc();
      chk("sat_stall", 32'(stall_cycles), 32'hFFFF);
      repeat (5) cyc();
      chk("sat_hold", 32'(stall_cycles), 32'hFFFF);
      chk("sat_timeout", 32'(mem_timeout), 1);
      idle_inputs();
      do_reset();
      #1 chk("final_run", 32'(ctrl), 32'(C_NORM));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
